instr_fetch_unit: RTL and testbench
===================================

// Module: instr_fetch_unit
// PURPOSE
//   Upstream fetch stage of the multi-cycle CPU. Holds the PC, fetches one 32-bit instruction
//   per request from instruction memory over a req/ready handshake, and holds it stable in the
//   instruction register feeding Control_Unit.instruction. It computes the next PC from the
//   Control_Unit outputs Branch, branch_taken and Jump, using the instruction's imm field.
// PARAMETERS
//   PC_WIDTH   12      word-address width of PC / imem_addr (>=12)
//   RESET_PC   0       PC value loaded on reset
//   CNT_WIDTH  16      width of retired-instruction counter
// PORTS
//   clk          in   1         clock, all logic on rising edge
//   reset        in   1         synchronous, active-low reset (0 = reset)
//   fetch_en     in   1         control unit is in FETCH and requests an instruction
//   pc_update    in   1         1-cycle pulse: current instruction retired, advance PC
//   Branch       in   1         current instruction is a conditional branch
//   branch_taken in   1         branch condition true (valid with pc_update)
//   Jump         in   1         current instruction is JUMP
//   imem_req     out  1         instruction memory read request
//   imem_addr    out  PC_WIDTH  read word address (= pc)
//   imem_ready   in   1         imem_rdata valid this cycle
//   imem_rdata   in   32        instruction word from memory
//   instruction  out  32        instruction register {op[31:27],rs,rt,rd,imm[11:0]}
//   instr_valid  out  1         instruction register holds a fetched, unretired instruction
//   pc           out  PC_WIDTH  address of the instruction in the register / next fetch
//   instr_count  out  CNT_WIDTH retired-instruction count, wraps
//   seq_err      out  1         sticky: pc_update received when instr_valid=0
// BEHAVIOUR
//   Reset (reset=0 at clk edge): state=IDLE, pc=RESET_PC, instruction=0, instr_valid=0,
//     imem_req=0, instr_count=0, seq_err=0. Takes effect in any state, including WAIT
//     (outstanding request abandoned; a late imem_ready is ignored).
//   FSM, registered state; imem_req = (state==WAIT); imem_addr = pc at all times.
//   - IDLE: fetch_en=1 -> WAIT. imem_ready ignored.
//   - WAIT: imem_req=1, imem_addr stable. At an edge with imem_ready=1: instruction<=imem_rdata,
//     instr_valid<=1 -> HOLD. Otherwise stay (unbounded wait states). fetch_en ignored.
//   - HOLD: instruction and pc held stable. fetch_en ignored. pc_update=1 -> pc<=next_pc,
//     instr_valid<=0, instr_count<=instr_count+1 -> IDLE.
//   Minimum latency: fetch_en sampled at edge E -> imem_req high after E; imem_ready at E+1
//     -> instr_valid high after E+1 (2 cycles).
//   next_pc, priority order, all modulo 2^PC_WIDTH:
//     1. Jump=1: zero-extended imm (absolute word address); Branch ignored.
//     2. Branch=1 and branch_taken=1: pc + 1 + sign-extended imm (imm[11] = sign).
//     3. Otherwise, including Branch=1 with branch_taken=0: pc + 1.
//   pc_update in IDLE or WAIT: no PC/count change, seq_err<=1 (cleared only by reset).
//   pc_update and fetch_en in the same HOLD cycle: pc_update acts, and the FSM goes to IDLE.
//     The next fetch needs a new fetch_en.
// TESTING
//   1. Hold reset=0 for 2 edges -> pc=0, instr_valid=0, imem_req=0, instr_count=0, seq_err=0.
//   2. Sequential ADD fetches, imem_ready 1 cycle after req -> imem_addr 0,1,2; instruction
//      equals each imem_rdata; instr_count=3 after 3 pc_update pulses.
//   3. At pc=5, imm=0x004, Branch=1, branch_taken=1 -> pc=10.
//      Same with branch_taken=0 -> pc=6.
//      At pc=2, imm=0xFFE (-2), taken -> pc=1.
//   4. Jump=1, Branch=1, imm=0x003 -> pc=3 (Jump wins).
//      pc=0xFFF, no branch -> pc=0 (wrap).
//   5. imem_ready held low 3 cycles -> imem_req stays 1, imem_addr unchanged,
//      instr_valid=0 until ready.
//      Reset=0 during WAIT -> IDLE, imem_req=0 next cycle; a later imem_ready is ignored.
//   6. pc_update pulse in IDLE -> pc unchanged, seq_err=1, stays 1 until reset.

Source files
------------

// File: rtl/instr_fetch_unit_if.sv
// ----------------------------------------------------------------------------
// instr_fetch_unit_if
//   Instruction-memory read channel between the fetch unit and its memory.
//   A request is held high with a stable address until the memory answers
//   with imem_ready; imem_rdata is valid only in that cycle.
//
//   Signals
//     imem_req    master -> slave  read request (high while waiting)
//     imem_addr   master -> slave  word address, PC_WIDTH bits
//     imem_ready  slave  -> master imem_rdata valid this cycle
//     imem_rdata  slave  -> master 32-bit instruction word
// ----------------------------------------------------------------------------
interface instr_fetch_unit_if #(
    parameter int PC_WIDTH = 12
);
    logic                imem_req;
    logic [PC_WIDTH-1:0] imem_addr;
    logic                imem_ready;
    logic [31:0]         imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ready,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ready,
        output imem_rdata
    );
endinterface

// File: rtl/instr_fetch_unit.sv
// ----------------------------------------------------------------------------
// instr_fetch_unit
//   Upstream fetch stage of the multi-cycle CPU. Holds the PC, fetches one
//   instruction per request over the imem handshake, and keeps it in the
//   instruction register until the control unit retires it with pc_update.
//   On retirement the PC advances to the next-PC selected by Jump / Branch /
//   branch_taken, using the imm field of the held instruction.
//
//   Ports
//     clk           clock, rising edge
//     reset         synchronous, active-low reset
//     fetch_en      control unit requests a fetch (acted on in IDLE)
//     pc_update     1-cycle pulse: retire held instruction, advance PC
//     Branch        held instruction is a conditional branch
//     branch_taken  branch condition true (valid with pc_update)
//     Jump          held instruction is a jump (absolute imm target)
//     imem          instruction-memory read channel (master side)
//     instruction   instruction register {op,rs,rt,rd,imm[11:0]}
//     instr_valid   instruction register holds an unretired instruction
//     pc            address of the held instruction / next fetch
//     instr_count   retired-instruction counter, wraps
//     seq_err       sticky: pc_update seen with no valid instruction
// ----------------------------------------------------------------------------
module instr_fetch_unit #(
    parameter int                  PC_WIDTH  = 12,
    parameter logic [PC_WIDTH-1:0] RESET_PC  = '0,
    parameter int                  CNT_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  fetch_en,
    input  logic                  pc_update,
    input  logic                  Branch,
    input  logic                  branch_taken,
    input  logic                  Jump,
    instr_fetch_unit_if.master    imem,
    output logic [31:0]           instruction,
    output logic                  instr_valid,
    output logic [PC_WIDTH-1:0]   pc,
    output logic [CNT_WIDTH-1:0]  instr_count,
    output logic                  seq_err
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_HOLD = 2'd2
    } state_t;

    state_t               r_state;
    logic [PC_WIDTH-1:0]  r_pc;
    logic [31:0]          r_instruction;
    logic                 r_instr_valid;
    logic                 r_imem_req;
    logic [CNT_WIDTH-1:0] r_instr_count;
    logic                 r_seq_err;

    logic [11:0]          w_imm;
    logic [PC_WIDTH-1:0]  w_imm_zext;
    logic [PC_WIDTH-1:0]  w_imm_sext;
    logic [PC_WIDTH-1:0]  w_pc_seq;
    logic [PC_WIDTH-1:0]  w_next_pc;

    // Immediate of the held instruction, widened both ways. PC_WIDTH >= 12,
    // so the size cast of a signed value performs the sign extension.
    assign w_imm      = r_instruction[11:0];
    assign w_imm_zext = PC_WIDTH'(w_imm);
    assign w_imm_sext = PC_WIDTH'($signed(w_imm));
    assign w_pc_seq   = r_pc + PC_WIDTH'(1);

    // Next-PC selection; Jump has priority over a taken branch. All sums
    // wrap naturally at PC_WIDTH bits.
    // NOTE: every always_comb output gets a default first, so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        w_next_pc = w_pc_seq;
        if (Jump) begin
            w_next_pc = w_imm_zext;
        end else if (Branch && branch_taken) begin
            w_next_pc = w_pc_seq + w_imm_sext;
        end
    end

    // Single registered FSM. imem_req is a registered copy of (state == WAIT)
    // so the memory sees a glitch-free request.
    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge values of the others.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state       <= S_IDLE;
            r_pc          <= RESET_PC;
            r_instruction <= '0;
            r_instr_valid <= 1'b0;
            r_imem_req    <= 1'b0;
            r_instr_count <= '0;
            r_seq_err     <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    // Retiring with nothing fetched is a sequencing error.
                    if (pc_update) begin
                        r_seq_err <= 1'b1;
                    end
                    if (fetch_en) begin
                        r_state    <= S_WAIT;
                        r_imem_req <= 1'b1;
                    end
                end

                S_WAIT: begin
                    // fetch_en is ignored; address stays on r_pc until ready.
                    if (pc_update) begin
                        r_seq_err <= 1'b1;
                    end
                    if (imem.imem_ready) begin
                        r_instruction <= imem.imem_rdata;
                        r_instr_valid <= 1'b1;
                        r_imem_req    <= 1'b0;
                        r_state       <= S_HOLD;
                    end
                end

                S_HOLD: begin
                    // A simultaneous fetch_en is dropped: the next fetch
                    // needs a fresh request from IDLE.
                    if (pc_update) begin
                        r_pc          <= w_next_pc;
                        r_instr_valid <= 1'b0;
                        r_instr_count <= r_instr_count + CNT_WIDTH'(1);
                        r_state       <= S_IDLE;
                    end
                end

                default: begin
                    r_state    <= S_IDLE;
                    r_imem_req <= 1'b0;
                end
            endcase
        end
    end

    assign imem.imem_req  = r_imem_req;
    assign imem.imem_addr = r_pc;
    assign instruction    = r_instruction;
    assign instr_valid    = r_instr_valid;
    assign pc             = r_pc;
    assign instr_count    = r_instr_count;
    assign seq_err        = r_seq_err;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// ----------------------------------------------------------------------------
// tb_instr_fetch_unit
//   Directed plus randomized stimulus for instr_fetch_unit. The bench plays
//   the instruction memory itself and keeps an architectural model of the
//   PC, retired count and error flag computed with plain integer arithmetic.
//   Inputs change and outputs are sampled on the falling edge.
// ----------------------------------------------------------------------------
module tb_instr_fetch_unit;

    localparam int PC_WIDTH  = 12;
    localparam int CNT_WIDTH = 16;

    logic                 clk;
    logic                 reset;
    logic                 fetch_en;
    logic                 pc_update;
    logic                 Branch;
    logic                 branch_taken;
    logic                 Jump;
    logic [31:0]          instruction;
    logic                 instr_valid;
    logic [PC_WIDTH-1:0]  pc;
    logic [CNT_WIDTH-1:0] instr_count;
    logic                 seq_err;

    instr_fetch_unit_if #(.PC_WIDTH(PC_WIDTH)) imem_bus ();

    instr_fetch_unit #(
        .PC_WIDTH  (PC_WIDTH),
        .RESET_PC  ('0),
        .CNT_WIDTH (CNT_WIDTH)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .fetch_en     (fetch_en),
        .pc_update    (pc_update),
        .Branch       (Branch),
        .branch_taken (branch_taken),
        .Jump         (Jump),
        .imem         (imem_bus),
        .instruction  (instruction),
        .instr_valid  (instr_valid),
        .pc           (pc),
        .instr_count  (instr_count),
        .seq_err      (seq_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Architectural model
    int          m_pc;
    int          m_cnt;
    logic        m_serr;
    logic [31:0] m_instr;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_pc    = 0;
        m_cnt   = 0;
        m_serr  = 1'b0;
        m_instr = '0;
    endtask

    // Hold reset low for the given number of edges; ends on a falling edge.
    task automatic do_reset(input int edges);
        fetch_en            = 1'b0;
        pc_update           = 1'b0;
        imem_bus.imem_ready = 1'b0;
        reset               = 1'b0;
        repeat (edges) @(negedge clk);
        reset = 1'b1;
        model_reset();
    endtask

    // Request one fetch, answer after 'waits' extra cycles with 'word'.
    task automatic fetch(input logic [31:0] word, input int waits);
        fetch_en = 1'b1;
        @(negedge clk);
        fetch_en = 1'b0;
        check("req_after_fetch_en", imem_bus.imem_req, 1);
        check("addr_eq_pc", imem_bus.imem_addr, m_pc);
        for (int i = 0; i < waits; i++) begin
            @(negedge clk);
            check("req_held_in_wait", imem_bus.imem_req, 1);
            check("addr_stable_in_wait", imem_bus.imem_addr, m_pc);
            check("valid_low_in_wait", instr_valid, 0);
        end
        imem_bus.imem_ready = 1'b1;
        imem_bus.imem_rdata = word;
        @(negedge clk);
        imem_bus.imem_ready = 1'b0;
        imem_bus.imem_rdata = $urandom;
        m_instr = word;
        check("valid_after_ready", instr_valid, 1);
        check("instr_captured", instruction, m_instr);
        check("req_drop_after_ready", imem_bus.imem_req, 0);
    endtask

    // Retire the held instruction; optionally assert fetch_en in the same cycle.
    task automatic retire(input logic j, input logic b, input logic t, input logic fe);
        int imm;
        imm = int'(m_instr[11:0]);
        if (j) begin
            m_pc = imm;
        end else if (b && t) begin
            if (imm >= 2048) imm = imm - 4096;
            m_pc = (m_pc + 1 + imm) & 32'hFFF;
        end else begin
            m_pc = (m_pc + 1) & 32'hFFF;
        end
        m_cnt = (m_cnt + 1) & 32'hFFFF;
        pc_update    = 1'b1;
        Jump         = j;
        Branch       = b;
        branch_taken = t;
        fetch_en     = fe;
        @(negedge clk);
        pc_update    = 1'b0;
        Jump         = 1'b0;
        Branch       = 1'b0;
        branch_taken = 1'b0;
        fetch_en     = 1'b0;
        check("pc_after_retire", pc, m_pc);
        check("valid_cleared", instr_valid, 0);
        check("count_after_retire", instr_count, m_cnt);
        check("seq_err_after_retire", seq_err, m_serr);
        if (fe) begin
            @(negedge clk);
            check("no_fetch_without_new_en", imem_bus.imem_req, 0);
        end
    endtask

    // pc_update with no valid instruction held.
    task automatic stray_update();
        pc_update = 1'b1;
        @(negedge clk);
        pc_update = 1'b0;
        m_serr = 1'b1;
        check("stray_pc_unchanged", pc, m_pc);
        check("stray_count_unchanged", instr_count, m_cnt);
        check("stray_seq_err_set", seq_err, 1);
    endtask

    function automatic logic [31:0] word_with_imm(input logic [11:0] imm);
        logic [31:0] w;
        w = $urandom;
        w[11:0] = imm;
        return w;
    endfunction

    initial begin
        reset               = 1'b1;
        fetch_en            = 1'b0;
        pc_update           = 1'b0;
        Branch              = 1'b0;
        branch_taken        = 1'b0;
        Jump                = 1'b0;
        imem_bus.imem_ready = 1'b0;
        imem_bus.imem_rdata = '0;
        model_reset();
        @(negedge clk);

        // Reset state
        do_reset(2);
        check("rst_pc", pc, 0);
        check("rst_valid", instr_valid, 0);
        check("rst_req", imem_bus.imem_req, 0);
        check("rst_count", instr_count, 0);
        check("rst_seq_err", seq_err, 0);
        check("rst_instruction", instruction, 0);

        // Three sequential ADD fetches at addresses 0,1,2
        for (int i = 0; i < 3; i++) begin
            fetch({5'b00001, 27'($urandom)}, 0);
            retire(1'b0, 1'b0, 1'b0, 1'b0);
        end
        check("count_three", instr_count, 3);

        // Advance to pc=5, taken branch +4 -> 10
        fetch(word_with_imm(12'h000), 0);
        retire(1'b0, 1'b0, 1'b0, 1'b0);
        fetch(word_with_imm(12'h000), 0);
        retire(1'b0, 1'b0, 1'b0, 1'b0);
        check("pc_five", pc, 5);
        fetch(word_with_imm(12'h004), 0);
        retire(1'b0, 1'b1, 1'b1, 1'b0);
        check("branch_taken_pc", pc, 10);

        // Back to 5, not-taken branch -> 6
        fetch(word_with_imm(12'h005), 0);
        retire(1'b1, 1'b0, 1'b0, 1'b0);
        fetch(word_with_imm(12'h004), 0);
        retire(1'b0, 1'b1, 1'b0, 1'b0);
        check("branch_not_taken_pc", pc, 6);

        // pc=2, imm=-2 taken -> 1
        fetch(word_with_imm(12'h002), 0);
        retire(1'b1, 1'b0, 1'b0, 1'b0);
        fetch(word_with_imm(12'hFFE), 0);
        retire(1'b0, 1'b1, 1'b1, 1'b0);
        check("branch_negative_pc", pc, 1);

        // Jump wins over Branch
        fetch(word_with_imm(12'h003), 0);
        retire(1'b1, 1'b1, 1'b1, 1'b0);
        check("jump_priority_pc", pc, 3);

        // Wrap from 0xFFF to 0
        fetch(word_with_imm(12'hFFF), 0);
        retire(1'b1, 1'b0, 1'b0, 1'b0);
        check("pc_fff", pc, 12'hFFF);
        fetch(word_with_imm(12'h123), 0);
        retire(1'b0, 1'b0, 1'b0, 1'b0);
        check("pc_wrap", pc, 0);

        // Three wait states
        fetch($urandom, 3);
        retire(1'b0, 1'b0, 1'b0, 1'b0);

        // pc_update together with fetch_en in HOLD
        fetch($urandom, 1);
        retire(1'b0, 1'b0, 1'b0, 1'b1);

        // Reset during WAIT abandons the request; a late ready is ignored
        fetch_en = 1'b1;
        @(negedge clk);
        fetch_en = 1'b0;
        check("req_before_wait_reset", imem_bus.imem_req, 1);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        model_reset();
        check("wait_reset_req", imem_bus.imem_req, 0);
        check("wait_reset_pc", pc, 0);
        check("wait_reset_count", instr_count, 0);
        imem_bus.imem_ready = 1'b1;
        imem_bus.imem_rdata = 32'hDEAD_BEEF;
        @(negedge clk);
        imem_bus.imem_ready = 1'b0;
        check("late_ready_valid", instr_valid, 0);
        check("late_ready_instr", instruction, 0);
        check("late_ready_req", imem_bus.imem_req, 0);

        // Stray pc_update in IDLE sets sticky seq_err
        stray_update();
        repeat (3) @(negedge clk);
        check("seq_err_sticky_idle", seq_err, 1);
        fetch($urandom, 0);
        retire(1'b0, 1'b0, 1'b0, 1'b0);
        check("seq_err_sticky_after_retire", seq_err, 1);
        do_reset(1);
        check("seq_err_cleared_by_reset", seq_err, 0);

        // Randomized fetch/retire traffic
        for (int i = 0; i < 40; i++) begin
            logic j, b, t, fe;
            j  = ($urandom_range(0, 3) == 0);
            b  = 1'($urandom);
            t  = 1'($urandom);
            fe = ($urandom_range(0, 4) == 0);
            fetch($urandom, int'($urandom_range(0, 2)));
            retire(j, b, t, fe);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
